// File: rtl/apb_fabric_timer.sv
// ---------------------------------------------------------------------------
// apb_fabric_timer
// APB3 slave timer sitting behind the MSS APB master in the FPGA fabric.
// A prescaled down-counter runs in one-shot or periodic mode. Its interrupt
// flag, masked by IE and registered, drives the MSS FABINT input.
//
// Ports
//   PCLK     in   fabric clock (MSS FAB_CLK)
//   PRESERN  in   asynchronous active-low reset (MSS M2FRESETn)
//   PSEL     in   APB select
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write
//   PADDR    in   [7:0] byte address, [4:2] decoded
//   PWDATA   in   [31:0] write data
//   PRDATA   out  [31:0] read data, combinational, 0 while PSEL=0
//   PREADY   out  tied 1 (zero wait states)
//   PSLVERR  out  unmapped access or write to VALUE during the access phase
//   FABINT   out  level-high interrupt (flag & IE, registered)
//
// Register map (PADDR[4:2])
//   0 CTRL  [0] EN  [1] PERIODIC  [2] IE
//   1 LOAD  [WIDTH-1:0]
//   2 VALUE read-only current count
//   3 PRESCALE [PRE_WIDTH-1:0]
//   4 STATUS [0] IRQ flag, write 1 to clear
// ---------------------------------------------------------------------------
module apb_fabric_timer #(
   parameter int WIDTH     = 32,
   parameter int PRE_WIDTH = 16
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        FABINT
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_LOAD   = 3'd1;
   localparam logic [2:0] ADDR_VALUE  = 3'd2;
   localparam logic [2:0] ADDR_PRE    = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   localparam logic [WIDTH-1:0]     ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRE_WIDTH-1:0] ONE_P = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

   state_e               state_q,  state_d;
   logic                 per_q,    per_d;
   logic                 ie_q,     ie_d;
   logic [WIDTH-1:0]     load_q,   load_d;
   logic [WIDTH-1:0]     value_q,  value_d;
   logic [PRE_WIDTH-1:0] pre_q,    pre_d;
   logic [PRE_WIDTH-1:0] pcnt_q,   pcnt_d;
   logic                 flag_q,   flag_d;
   logic                 fabint_q, fabint_d;

   logic [2:0] addr_s;
   logic       access_s;
   logic       err_s;
   logic       wr_s;
   logic       ctrl_wr_s;
   logic       status_wr_s;
   logic       tick_s;
   logic       set_s;
   logic       unused_s;

   assign addr_s   = PADDR[4:2];
   assign access_s = PSEL & PENABLE;
   // An errored write must not touch any register, so it is removed from wr_s.
   assign err_s    = access_s & ((addr_s > ADDR_STATUS) | (PWRITE & (addr_s == ADDR_VALUE)));
   assign wr_s     = access_s & PWRITE & ~err_s;
   assign ctrl_wr_s   = wr_s & (addr_s == ADDR_CTRL);
   assign status_wr_s = wr_s & (addr_s == ADDR_STATUS);
   // pcnt may sit above a freshly lowered PRESCALE; it then wraps without a tick.
   assign tick_s   = (state_q == ST_RUN) & (pcnt_q == pre_q);

   assign PREADY   = 1'b1;
   assign PSLVERR  = err_s;
   assign FABINT   = fabint_q;
   assign unused_s = ^{PADDR[7:5], PADDR[1:0], PWDATA};

   // Next-state logic: run/idle control, prescaler, counter, flag and register writes.
   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      ie_d     = ie_q;
      load_d   = load_q;
      value_d  = value_q;
      pre_d    = pre_q;
      pcnt_d   = pcnt_q;
      flag_d   = flag_q;
      set_s    = 1'b0;
      fabint_d = flag_q & ie_q;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_wr_s && PWDATA[0]) begin
               state_d = ST_RUN;
               value_d = load_q;
               pcnt_d  = {PRE_WIDTH{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ctrl_wr_s && !PWDATA[0]) begin
               // Stopping freezes VALUE and pcnt where they are.
               state_d = ST_IDLE;
            end else if (tick_s) begin
               pcnt_d = {PRE_WIDTH{1'b0}};
               if (value_q != {WIDTH{1'b0}}) begin
                  value_d = value_q - ONE_W;
               end else begin
                  set_s = 1'b1;
                  if (per_q) begin
                     value_d = load_q;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               pcnt_d = pcnt_q + ONE_P;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (ctrl_wr_s) begin
         per_d = PWDATA[1];
         ie_d  = PWDATA[2];
      end else begin
         per_d = per_q;
         ie_d  = ie_q;
      end

      if (wr_s && (addr_s == ADDR_LOAD)) begin
         load_d = PWDATA[WIDTH-1:0];
      end else begin
         load_d = load_q;
      end

      if (wr_s && (addr_s == ADDR_PRE)) begin
         pre_d = PWDATA[PRE_WIDTH-1:0];
      end else begin
         pre_d = pre_q;
      end

      // A set in the same cycle as a write-1-clear wins.
      if (set_s) begin
         flag_d = 1'b1;
      end else if (status_wr_s && PWDATA[0]) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end
   end

   // State and register storage.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q  <= ST_IDLE;
         per_q    <= 1'b0;
         ie_q     <= 1'b0;
         load_q   <= {WIDTH{1'b0}};
         value_q  <= {WIDTH{1'b0}};
         pre_q    <= {PRE_WIDTH{1'b0}};
         pcnt_q   <= {PRE_WIDTH{1'b0}};
         flag_q   <= 1'b0;
         fabint_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         ie_q     <= ie_d;
         load_q   <= load_d;
         value_q  <= value_d;
         pre_q    <= pre_d;
         pcnt_q   <= pcnt_d;
         flag_q   <= flag_d;
         fabint_q <= fabint_d;
      end
   end

   // Read mux; returns 0 outside a selected transfer and for unmapped addresses.
   always_comb begin
      PRDATA = 32'h0000_0000;
      if (PSEL) begin
         case (addr_s)
            ADDR_CTRL:   PRDATA = {29'd0, ie_q, per_q, (state_q == ST_RUN)};
            ADDR_LOAD:   PRDATA = 32'(load_q);
            ADDR_VALUE:  PRDATA = 32'(value_q);
            ADDR_PRE:    PRDATA = 32'(pre_q);
            ADDR_STATUS: PRDATA = {31'd0, flag_q};
            default:     PRDATA = 32'h0000_0000;
         endcase
      end else begin
         PRDATA = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_apb_fabric_timer.sv
module tb_apb_fabric_timer;

   logic        PCLK = 1'b0;
   logic        PRESERN = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [7:0]  PADDR = 8'h00;
   logic [31:0] PWDATA = 32'h0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        FABINT;

   apb_fabric_timer #(.WIDTH(32), .PRE_WIDTH(16)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .FABINT(FABINT)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   // Behavioural timer state
   typedef struct packed {
      logic        run;
      logic        per;
      logic        ie;
      logic [31:0] load;
      logic [31:0] val;
      logic [15:0] pre;
      logic [15:0] pcnt;
      logic        flag;
      logic        fab;
   } model_t;

   model_t m;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      logic        err;
      string       name;
   } exp_t;

   exp_t sb[$];

   function automatic logic is_err(input logic [7:0] a, input logic w);
      logic [2:0] r;
      r = a[4:2];
      return (r > 3'd4) || (w && (r == 3'd2));
   endfunction

   function automatic logic [31:0] model_read(input model_t s, input logic [7:0] a);
      logic [2:0] r;
      r = a[4:2];
      case (r)
         3'd0: return {29'd0, s.ie, s.per, s.run};
         3'd1: return s.load;
         3'd2: return s.val;
         3'd3: return {16'd0, s.pre};
         3'd4: return {31'd0, s.flag};
         default: return 32'd0;
      endcase
   endfunction

   // One clock of timer behaviour given the bus inputs seen at the edge.
   function automatic model_t model_step(input model_t s, input logic sel, input logic en,
                                         input logic wr, input logic [7:0] a, input logic [31:0] d);
      model_t n;
      logic   do_wr;
      logic   set;
      logic [2:0] r;
      n = s;
      r = a[4:2];
      do_wr = sel && en && wr && !is_err(a, wr);
      set = 1'b0;
      n.fab = s.flag && s.ie;
      if (do_wr && r == 3'd0 && !d[0]) begin
         n.run = 1'b0;
      end else if (do_wr && r == 3'd0 && d[0] && !s.run) begin
         n.run = 1'b1;
         n.val = s.load;
         n.pcnt = 16'd0;
      end else if (s.run) begin
         if (s.pcnt == s.pre) begin
            n.pcnt = 16'd0;
            if (s.val == 32'd0) begin
               set = 1'b1;
               if (s.per) n.val = s.load;
               else n.run = 1'b0;
            end else begin
               n.val = s.val - 32'd1;
            end
         end else begin
            n.pcnt = s.pcnt + 16'd1;
         end
      end
      if (do_wr) begin
         case (r)
            3'd0: begin n.per = d[1]; n.ie = d[2]; end
            3'd1: n.load = d;
            3'd3: n.pre = d[15:0];
            3'd4: if (d[0]) n.flag = 1'b0;
            default: ;
         endcase
      end
      if (set) n.flag = 1'b1;
      return n;
   endfunction

   always @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) m <= '0;
      else m <= model_step(m, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every access phase, tracks FABINT each cycle.
   always @(negedge PCLK) begin
      exp_t e;
      chk("fabint", 32'(FABINT), 32'(m.fab));
      chk("pready", 32'(PREADY), 32'd1);
      if (PSEL && PENABLE) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: access phase with no expected entry");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
            if (e.is_read) chk(e.name, PRDATA, e.data);
         end
      end else begin
         chk("pslverr_idle", 32'(PSLVERR), 32'd0);
         if (!PSEL) chk("prdata_idle", PRDATA, 32'd0);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the access phase.
   task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input string nm, input logic use_c, input logic [31:0] c);
      exp_t e;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      e.is_read = !wr;
      e.err = is_err(a, wr);
      e.data = use_c ? c : model_read(m, a);
      e.name = nm;
      sb.push_back(e);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      apb(1'b1, a, d, "wr", 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [7:0] a, input string nm);
      apb(1'b0, a, 32'd0, nm, 1'b0, 32'd0);
   endtask

   task automatic rdc(input logic [7:0] a, input logic [31:0] c, input string nm);
      apb(1'b0, a, 32'd0, nm, 1'b1, c);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge PCLK); #1; end
   endtask

   task automatic wait_fab(output int t, output logic ok);
      ok = 1'b0;
      t = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge PCLK); #1;
         if (FABINT) begin t = cyc; ok = 1'b1; break; end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0, t1;
      logic ok0, ok1;
      logic [2:0]  r;
      logic [7:0]  a;
      logic [31:0] d;

      repeat (3) @(posedge PCLK);
      #3 PRESERN = 1'b1;
      @(posedge PCLK); #1;

      // Reset state
      rdc(8'h00, 32'd0, "rst_ctrl");
      rdc(8'h04, 32'd0, "rst_load");
      rdc(8'h08, 32'd0, "rst_value");
      rdc(8'h0C, 32'd0, "rst_prescale");
      rdc(8'h10, 32'd0, "rst_status");
      rdc(8'h14, 32'd0, "unmapped_5");
      rdc(8'h1F, 32'd0, "unmapped_7");

      // One-shot, IE: expires after 4 ticks and stops
      wr(8'h04, 32'd3);
      wr(8'h0C, 32'd0);
      wr(8'h00, 32'h5);
      idle(10);
      rdc(8'h00, 32'h4, "oneshot_ctrl");
      rdc(8'h08, 32'd0, "oneshot_value");
      rdc(8'h10, 32'd1, "oneshot_flag");
      chk("oneshot_fabint", 32'(FABINT), 32'd1);
      wr(8'h10, 32'd1);
      idle(1);
      chk("oneshot_fabint_clr", 32'(FABINT), 32'd0);

      // Periodic: (2+1)*(4+1) = 15 cycles between flag sets
      wr(8'h04, 32'd2);
      wr(8'h0C, 32'd4);
      wr(8'h00, 32'h7);
      wait_fab(t0, ok0);
      chk("period_first_irq", 32'(ok0), 32'd1);
      wr(8'h10, 32'd1);
      idle(1);
      chk("period_fabint_drop", 32'(FABINT), 32'd0);
      wait_fab(t1, ok1);
      chk("period_second_irq", 32'(ok1), 32'd1);
      chk("period_interval", 32'(t1 - t0), 32'd15);
      wr(8'h00, 32'h0);
      wr(8'h10, 32'd1);

      // Set wins over clear: LOAD=0, PRESCALE=0 sets the flag every cycle
      wr(8'h04, 32'd0);
      wr(8'h0C, 32'd0);
      wr(8'h00, 32'h3);
      idle(3);
      wr(8'h10, 32'd1);
      rdc(8'h10, 32'd1, "set_wins");
      wr(8'h00, 32'h0);
      wr(8'h10, 32'd1);
      rdc(8'h10, 32'd0, "flag_cleared");

      // LOAD rewrite mid-count and errored VALUE write
      wr(8'h04, 32'd10);
      wr(8'h0C, 32'd2);
      wr(8'h00, 32'h3);
      idle(6);
      wr(8'h04, 32'd5);
      wr(8'h08, 32'h55);
      rd(8'h08, "value_after_err");
      rdc(8'h04, 32'd5, "load_rewritten");
      for (int i = 0; i < 20; i++) begin
         idle(2);
         rd(8'h08, "value_track");
      end
      wr(8'h00, 32'h0);
      wr(8'h10, 32'd1);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = 3'($urandom_range(0, 7));
         a = {3'b000, r, 2'($urandom_range(0, 3))};
         case (r)
            3'd0: d = 32'($urandom_range(0, 7));
            3'd1: d = 32'($urandom_range(0, 12));
            3'd3: d = 32'($urandom_range(0, 5));
            3'd4: d = 32'($urandom_range(0, 1));
            default: d = $urandom;
         endcase
         if ($urandom_range(0, 1) == 0) apb(1'b1, a, d, "rnd_wr", 1'b0, 32'd0);
         else apb(1'b0, a, 32'd0, "rnd_rd", 1'b0, 32'd0);
         idle($urandom_range(0, 4));
      end

      // Reset asserted mid-count
      wr(8'h00, 32'h0);
      wr(8'h04, 32'd7);
      wr(8'h0C, 32'd100);
      wr(8'h00, 32'h7);
      idle(5);
      rdc(8'h08, 32'd7, "prereset_value");
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h08;
      #2 PRESERN = 1'b0;
      #1 chk("async_rst_value", PRDATA, 32'd0);
      PADDR = 8'h00;
      #1 chk("async_rst_ctrl", PRDATA, 32'd0);
      PADDR = 8'h10;
      #1 chk("async_rst_flag", PRDATA, 32'd0);
      chk("async_rst_fabint", 32'(FABINT), 32'd0);
      PSEL = 1'b0;
      repeat (2) @(posedge PCLK);
      #3 PRESERN = 1'b1;
      @(posedge PCLK); #1;
      idle(120);
      chk("post_rst_fabint", 32'(FABINT), 32'd0);
      rdc(8'h00, 32'd0, "post_rst_ctrl");
      rdc(8'h10, 32'd0, "post_rst_flag");

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_fabric_timer.md
Name: apb_fabric_timer

Overview:
- APB3 slave in the FPGA fabric, directly downstream of the MSS APB master interface (MSSPSEL/MSSPADDR/MSSPWDATA...).
- Clocked by the MSS fabric clock (FAB_CLK, 100 MHz). Provides a prescaled down-counter with one-shot or periodic mode.
- Its interrupt drives the MSS FABINT input.

Parameters:
- WIDTH, 32, counter and LOAD register width (8..32).
- PRE_WIDTH, 16, prescaler register width.

Ports:
- PCLK  in  1  fabric clock (MSS FAB_CLK).
- PRESERN  in  1  asynchronous active-low reset (MSS M2FRESETn).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  1 = write.
- PADDR  in  8  byte address; only [4:2] decoded, [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error response.
- FABINT  out  1  interrupt to MSS, level-high.

Behaviour:
- Register map (PADDR[4:2]):
  - 0 CTRL RW: [0] EN, [1] PERIODIC, [2] IE.
  - 1 LOAD RW: [WIDTH-1:0].
  - 2 VALUE RO: current count.
  - 3 PRESCALE RW: [PRE_WIDTH-1:0].
  - 4 STATUS: [0] IRQ flag; read returns flag, writing 1 clears it.
  - 5..7 unmapped.
- Unused PRDATA bits read 0.
- Write commits on the rising edge where PSEL & PENABLE & PWRITE.
- PRDATA is combinational from PADDR while PSEL=1, and 0 when PSEL=0.
- PSLVERR = PSEL & PENABLE & (unmapped address, or a write to VALUE). An errored write changes nothing.
- Reset (async assert, sync release): all registers, counters and IRQ flag = 0; PRDATA=0; PSLVERR=0; FABINT=0; PREADY=1.
- Prescaler:
  - pcnt counts 0..PRESCALE while EN=1.
  - A tick is generated on the cycle pcnt==PRESCALE; pcnt then wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
- States: IDLE (EN=0) and RUN (EN=1).
- IDLE->RUN on a CTRL write with EN=1 while EN=0:
  - VALUE<=LOAD and pcnt<=0 on the same edge.
  - The first tick occurs PRESCALE+1 cycles later.
- RUN, on each tick:
  - VALUE!=0: VALUE<=VALUE-1.
  - VALUE==0: IRQ flag<=1. If PERIODIC, VALUE<=LOAD; else EN<=0, VALUE holds 0, go to IDLE.
- RUN->IDLE on a CTRL write with EN=0: VALUE and pcnt hold their values. A later re-enable reloads LOAD.
- CTRL write with EN=1 while already RUN: PERIODIC and IE update, no reload.
- LOAD write while RUN: takes effect only at the next reload.
- PRESCALE write while RUN: new compare value applies immediately. If pcnt > new PRESCALE, pcnt continues counting up and wraps at 2^PRE_WIDTH to 0 without generating a tick.
- Periodic interval is (LOAD+1)*(PRESCALE+1) cycles. LOAD=0 periodic gives the flag every tick.
- Flag set and STATUS write-1-clear in the same cycle: set wins, flag stays 1.
- FABINT = flag & IE, registered (one cycle after the flag changes). Changing IE masks or unmasks the output without changing the flag.
- Reset asserted mid-count: immediate return to the reset state, no interrupt.

Test Plan:
- Reset then read all five registers -> all read 0, PSLVERR=0, FABINT=0. Read 0x14 -> PSLVERR=1 in the access phase, PRDATA=0.
- LOAD=3, PRESCALE=0, CTRL=0x5 (one-shot, IE) -> VALUE steps 3,2,1,0. Flag set on the 4th tick. FABINT high the next cycle. EN reads 0 and VALUE stays 0.
- LOAD=2, PRESCALE=4, CTRL=0x7 -> flag every 15 cycles. Write STATUS=1 -> FABINT drops the next cycle and re-asserts 15 cycles after the previous set.
- Periodic, LOAD=0, PRESCALE=0; write STATUS=1 on a set cycle -> flag remains 1 (set wins).
- Running, LOAD=10 rewritten to 5 mid-count -> the current period finishes from 10, the next reload uses 5. Write VALUE -> PSLVERR=1 and VALUE unchanged.
- Assert PRESERN low mid-count with VALUE=7 -> VALUE, CTRL and the flag are 0 immediately, asynchronously. After release, no FABINT.
